// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller
//   Time-multiplexes a 4-digit seven-segment display. A single counter times
//   an all-off blanking gap followed by a lit phase for each digit in turn
//   (digit 0..3). This suppresses ghosting between digits. The controller
//   also holds the Y/OP values shown on the display. New values arrive via a
//   valid/ready handshake into a shadow register. They are copied to Y/OP
//   only at a frame boundary, so a frame never shows half-old, half-new data.
//
// Parameters
//   DIGIT_CYCLES  clk cycles each digit is lit (>= 1)
//   BLANK_CYCLES  clk cycles of all-anodes-off before each digit (0 = none)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   en          in   scan enable; 0 keeps the display dark
//   load_valid  in   new display value offered
//   load_ready  out  a value can be accepted (no commit pending)
//   y_in        in   [7:0] result to display
//   op_in       in   [3:0] opcode to display
//   anode       out  [3:0] active-low digit strobe
//   Y           out  [7:0] committed result
//   OP          out  [3:0] committed opcode
//   digit_idx   out  [1:0] current digit 0..3
//   frame_tick  out  one-cycle pulse after the digit-3 lit phase ends
module seven_seg_scan_controller #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] y_in,
  input  logic [3:0] op_in,
  output logic [3:0] anode,
  output logic [7:0] Y,
  output logic [3:0] OP,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2((MAX_CYCLES > 2) ? MAX_CYCLES : 2);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Without a blank phase the scan lives entirely in SHOW. This is also
  // where the scan (re)starts after reset or en=0.
  localparam state_t START_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       digit_n;
  logic [3:0]       anode_n;
  logic             tick_n;
  logic [11:0]      shadow, shadow_n;
  logic [11:0]      disp_n;
  logic             pending, pending_n;
  logic             show_end;
  logic             frame_end;
  logic             commit;

  // Active-low strobe with exactly one digit selected.
  function automatic logic [3:0] digit_strobe(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

  assign load_ready = ~pending;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    digit_n   = digit_idx;
    show_end  = 1'b0;

    if (!en) begin
      state_n = START_STATE;
      cnt_n   = '0;
      digit_n = '0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == DIGIT_LAST) begin
            show_end = 1'b1;
            cnt_n    = '0;
            digit_n  = digit_idx + 2'd1;
            state_n  = START_STATE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      endcase
    end

    frame_end = show_end && (digit_idx == 2'd3);
    tick_n    = frame_end;

    // The anode register is computed from the next state. This keeps the
    // strobe aligned with the phase it belongs to, not one cycle late.
    anode_n = (en && (state_n == SHOW)) ? digit_strobe(digit_n) : 4'b1111;

    // Commit and capture are mutually exclusive because capture needs
    // pending=0 and commit needs pending=1. While dark (en=0) there is no
    // frame to tear, so a pending value is taken straight away.
    commit    = pending && (!en || frame_end);
    disp_n    = {Y, OP};
    shadow_n  = shadow;
    pending_n = pending;
    if (commit) begin
      disp_n    = shadow;
      pending_n = 1'b0;
    end else if (load_valid && !pending) begin
      shadow_n  = {y_in, op_in};
      pending_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= START_STATE;
      cnt        <= '0;
      digit_idx  <= '0;
      anode      <= 4'b1111;
      frame_tick <= 1'b0;
      Y          <= '0;
      OP         <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= digit_n;
      anode      <= anode_n;
      frame_tick <= tick_n;
      Y          <= disp_n[11:4];
      OP         <= disp_n[3:0];
      shadow     <= shadow_n;
      pending    <= pending_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller
//   Drives two controllers with the same inputs: one with DIGIT_CYCLES=4 and
//   BLANK_CYCLES=2 (24-cycle frame), and one with DIGIT_CYCLES=4 and
//   BLANK_CYCLES=0 (16-cycle frame). A bench model tracks the time since
//   the scan (re)started and the handshake state, and derives every output
//   from that. Directed steps add literal expectations on top.
module tb_seven_seg_scan_controller;

  localparam int D = 4;

  logic       clk;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] y_in = '0;
  logic [3:0] op_in = '0;

  logic       load_ready_o [2];
  logic [3:0] anode_o      [2];
  logic [7:0] y_o          [2];
  logic [3:0] op_o         [2];
  logic [1:0] digit_o      [2];
  logic       tick_o       [2];

  int checks = 0;
  int errors = 0;

  // model state, one entry per instance
  int          t        [2];
  logic        pend     [2];
  logic [11:0] shadow_m [2];
  logic [11:0] disp_m   [2];

  logic [3:0] seq_b2 [24] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                              4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
                              4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};
  logic [3:0] seq_b0 [16] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                              4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7};

  seven_seg_scan_controller #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2)) dut_b2 (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready_o[0]),
    .y_in(y_in), .op_in(op_in), .anode(anode_o[0]), .Y(y_o[0]), .OP(op_o[0]),
    .digit_idx(digit_o[0]), .frame_tick(tick_o[0])
  );

  seven_seg_scan_controller #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0)) dut_b0 (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready_o[1]),
    .y_in(y_in), .op_in(op_in), .anode(anode_o[1]), .Y(y_o[1]), .OP(op_o[1]),
    .digit_idx(digit_o[1]), .frame_tick(tick_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int blank_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int slot_of(input int i);
    return blank_of(i) + D;
  endfunction

  function automatic int frame_of(input int i);
    return 4 * slot_of(i);
  endfunction

  // Cycle t of a running scan: position p in the frame, digit p/slot, and
  // dark during the first 'blank' cycles of each slot. The start cycle
  // (t=0) is always dark.
  function automatic logic [3:0] exp_anode(input int i);
    int p;
    logic [3:0] onehot;
    p = t[i] % frame_of(i);
    if (t[i] == 0 || (p % slot_of(i)) < blank_of(i)) return 4'b1111;
    onehot = 4'b0001 << (p / slot_of(i));
    return ~onehot;
  endfunction

  function automatic logic [1:0] exp_digit(input int i);
    return 2'((t[i] % frame_of(i)) / slot_of(i));
  endfunction

  function automatic logic exp_tick(input int i);
    return (t[i] > 0) && ((t[i] % frame_of(i)) == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        t[i]        <= 0;
        pend[i]     <= 1'b0;
        shadow_m[i] <= '0;
        disp_m[i]   <= '0;
      end else begin
        if (pend[i] && (!en || ((t[i] % frame_of(i)) == frame_of(i) - 1))) begin
          disp_m[i] <= shadow_m[i];
          pend[i]   <= 1'b0;
        end else if (load_valid && !pend[i]) begin
          shadow_m[i] <= {y_in, op_in};
          pend[i]     <= 1'b1;
        end
        t[i] <= en ? t[i] + 1 : 0;
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("anode", i, 32'(anode_o[i]), 32'(exp_anode(i)));
      chk("one_cold", i, 32'($countones(~anode_o[i]) <= 1), 32'd1);
      chk("digit_idx", i, 32'(digit_o[i]), 32'(exp_digit(i)));
      chk("frame_tick", i, 32'(tick_o[i]), 32'(exp_tick(i)));
      chk("Y", i, 32'(y_o[i]), 32'(disp_m[i][11:4]));
      chk("OP", i, 32'(op_o[i]), 32'(disp_m[i][3:0]));
      chk("load_ready", i, 32'(load_ready_o[i]), 32'(!pend[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_tick(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_o[0] && n < lim);
    chk("wait_frame_tick", 0, 32'(tick_o[0]), 32'd1);
  endtask

  task automatic wait_anode(input logic [3:0] a, input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (anode_o[0] !== a && n < lim);
    chk("wait_anode", 0, 32'(anode_o[0]), 32'(a));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_anode", 0, 32'(anode_o[0]), 32'hF);
    chk("rst_Y", 0, 32'(y_o[0]), 32'h0);
    chk("rst_ready", 0, 32'(load_ready_o[0]), 32'd1);
    chk("rst_tick", 0, 32'(tick_o[0]), 32'd0);
    chk("rst_anode_b0", 1, 32'(anode_o[1]), 32'hF);

    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i < 24) chk("seq_b2", i, 32'(anode_o[0]), 32'(seq_b2[i]));
      if (i >= 16) chk("seq_b0", i, 32'(anode_o[1]), 32'(seq_b0[i-16]));
      if (i == 23) chk("tick_b2_t23", 0, 32'(tick_o[0]), 32'd0);
      if (i == 24) chk("tick_b2_t24", 0, 32'(tick_o[0]), 32'd1);
      if (i == 16) chk("tick_b0_t16", 1, 32'(tick_o[1]), 32'd1);
    end

    // mid-frame load
    tick();
    load_valid = 1'b1; y_in = 8'hA5; op_in = 4'h3;
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_load", 0, 32'(load_ready_o[0]), 32'd0);
    chk("Y_held", 0, 32'(y_o[0]), 32'h00);

    // offered while pending: not captured until ready returns
    tick();
    load_valid = 1'b1; y_in = 8'h11; op_in = 4'hC;
    wait_frame_tick(40);
    chk("Y_commit_A5", 0, 32'(y_o[0]), 32'hA5);
    chk("OP_commit_3", 0, 32'(op_o[0]), 32'h3);
    chk("ready_back", 0, 32'(load_ready_o[0]), 32'd1);
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_11", 0, 32'(load_ready_o[0]), 32'd0);
    chk("Y_still_A5", 0, 32'(y_o[0]), 32'hA5);
    wait_frame_tick(40);
    chk("Y_commit_11", 0, 32'(y_o[0]), 32'h11);
    chk("OP_commit_C", 0, 32'(op_o[0]), 32'hC);

    // pending value, then drop en during digit 2
    tick();
    load_valid = 1'b1; y_in = 8'h5A; op_in = 4'h6;
    tick();
    load_valid = 1'b0;
    wait_anode(4'b1011, 40);
    tick();
    en = 1'b0;
    tick();
    @(negedge clk);
    chk("en0_anode", 0, 32'(anode_o[0]), 32'hF);
    chk("en0_Y", 0, 32'(y_o[0]), 32'h5A);
    chk("en0_OP", 0, 32'(op_o[0]), 32'h6);
    chk("en0_digit", 0, 32'(digit_o[0]), 32'd0);
    chk("en0_ready", 0, 32'(load_ready_o[0]), 32'd1);

    // capture while dark commits on the following edge
    tick();
    load_valid = 1'b1; y_in = 8'hC3; op_in = 4'h9;
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    chk("en0_cap_ready", 0, 32'(load_ready_o[0]), 32'd0);
    chk("en0_cap_Y_old", 0, 32'(y_o[0]), 32'h5A);
    tick();
    @(negedge clk);
    chk("en0_commit_Y", 0, 32'(y_o[0]), 32'hC3);
    chk("en0_commit_OP", 0, 32'(op_o[0]), 32'h9);

    // restart: blank of digit 0 first
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("restart_t0", 0, 32'(anode_o[0]), 32'hF);
    @(negedge clk);
    chk("restart_t1", 0, 32'(anode_o[0]), 32'hF);
    @(negedge clk);
    chk("restart_t2", 0, 32'(anode_o[0]), 32'hE);

    // async reset while lit with a pending value
    tick();
    load_valid = 1'b1; y_in = 8'h77; op_in = 4'h1;
    tick();
    load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_anode", 0, 32'(anode_o[0]), 32'hF);
    chk("arst_Y", 0, 32'(y_o[0]), 32'h0);
    chk("arst_OP", 0, 32'(op_o[0]), 32'h0);
    chk("arst_ready", 0, 32'(load_ready_o[0]), 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    load_valid = 1'b1; y_in = 8'h3C; op_in = 4'hE;
    tick();
    load_valid = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
